// File: rtl/tenb_frame_decoder.sv
// 8b/10b receive framer: hunts K28.5, decodes with running-disparity checks,
// strips K23.7 + CRC-32 trailer and forwards payload bytes with sop/eop flags.
module tenb_frame_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushin,
  input  logic [9:0] datain,
  output logic       pushout,
  output logic [7:0] dataout,
  output logic       sopout,
  output logic       eopout,
  output logic       frame_done,
  output logic       crc_ok,
  output logic       code_err
);

  typedef enum logic [1:0] {StIdle, StData, StCrc, StEnd} state_e;

  localparam logic [9:0] K285Neg = 10'b0101_111100;
  localparam logic [9:0] K285Pos = 10'b1010_000011;

  // Returns {valid, EDCBA} for an abcdei sub-block; K28 forms are valid.
  function automatic logic [5:0] dec6(input logic [5:0] c);
    unique case (c)
      6'b100111, 6'b011000: return {1'b1, 5'd0};
      6'b011101, 6'b100010: return {1'b1, 5'd1};
      6'b101101, 6'b010010: return {1'b1, 5'd2};
      6'b110001:            return {1'b1, 5'd3};
      6'b110101, 6'b001010: return {1'b1, 5'd4};
      6'b101001:            return {1'b1, 5'd5};
      6'b011001:            return {1'b1, 5'd6};
      6'b111000, 6'b000111: return {1'b1, 5'd7};
      6'b111001, 6'b000110: return {1'b1, 5'd8};
      6'b100101:            return {1'b1, 5'd9};
      6'b010101:            return {1'b1, 5'd10};
      6'b110100:            return {1'b1, 5'd11};
      6'b001101:            return {1'b1, 5'd12};
      6'b101100:            return {1'b1, 5'd13};
      6'b011100:            return {1'b1, 5'd14};
      6'b010111, 6'b101000: return {1'b1, 5'd15};
      6'b011011, 6'b100100: return {1'b1, 5'd16};
      6'b100011:            return {1'b1, 5'd17};
      6'b010011:            return {1'b1, 5'd18};
      6'b110010:            return {1'b1, 5'd19};
      6'b001011:            return {1'b1, 5'd20};
      6'b101010:            return {1'b1, 5'd21};
      6'b011010:            return {1'b1, 5'd22};
      6'b111010, 6'b000101: return {1'b1, 5'd23};
      6'b110011, 6'b001100: return {1'b1, 5'd24};
      6'b100110:            return {1'b1, 5'd25};
      6'b010110:            return {1'b1, 5'd26};
      6'b110110, 6'b001001: return {1'b1, 5'd27};
      6'b001110, 6'b001111, 6'b110000: return {1'b1, 5'd28};
      6'b101110, 6'b010001: return {1'b1, 5'd29};
      6'b011110, 6'b100001: return {1'b1, 5'd30};
      6'b101011, 6'b010100: return {1'b1, 5'd31};
      default:              return 6'd0;
    endcase
  endfunction

  function automatic logic [2:0] dec4(input logic [3:0] c);
    unique case (c)
      4'b1011, 4'b0100: return 3'd0;
      4'b1001:          return 3'd1;
      4'b0101:          return 3'd2;
      4'b1100, 4'b0011: return 3'd3;
      4'b1101, 4'b0010: return 3'd4;
      4'b1010:          return 3'd5;
      4'b0110:          return 3'd6;
      default:          return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Symbol classification
  logic [5:0] s6, d6;
  logic [3:0] s4;
  logic [2:0] ones6, ones4;
  logic       k28, k285, k237, kx7n, kx7p, a7n, a7p, is_k, bad4, sym_err;
  logic       rd_mid, rd_nx, derr;
  logic [7:0] sym_byte;

  assign s6    = {datain[0], datain[1], datain[2], datain[3], datain[4], datain[5]};
  assign s4    = {datain[6], datain[7], datain[8], datain[9]};
  assign d6    = dec6(s6);
  assign ones6 = 3'($countones(s6));
  assign ones4 = 3'($countones(s4));
  assign sym_byte = {dec4(s4), d6[4:0]};

  assign k28  = (s6 == 6'b001111) || (s6 == 6'b110000);
  assign k285 = (datain == K285Neg) || (datain == K285Pos);
  assign k237 = ((s6 == 6'b111010) && (s4 == 4'b1000)) || ((s6 == 6'b000101) && (s4 == 4'b0111));
  assign kx7n = (s6 == 6'b111010) || (s6 == 6'b110110) || (s6 == 6'b101110) || (s6 == 6'b011110);
  assign kx7p = (s6 == 6'b000101) || (s6 == 6'b001001) || (s6 == 6'b010001) || (s6 == 6'b100001);
  assign a7n  = (s6 == 6'b100011) || (s6 == 6'b010011) || (s6 == 6'b001011);
  assign a7p  = (s6 == 6'b110100) || (s6 == 6'b101100) || (s6 == 6'b011100);
  assign is_k = k28 || ((kx7n || kx7p) && ((s4 == 4'b0111) || (s4 == 4'b1000)));

  // A7/P7 and K28 pairings that no valid code word uses
  assign bad4 = (ones4 == 3'd0) || (ones4 == 3'd4)
             || ((s4 == 4'b1110) && (a7n || s6 == 6'b110000))
             || ((s4 == 4'b0001) && (a7p || s6 == 6'b001111))
             || ((s4 == 4'b0111) && !(a7n || kx7p || s6 == 6'b110000))
             || ((s4 == 4'b1000) && !(a7p || kx7n || s6 == 6'b001111));

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic [31:0] crc_q, crc_d, rx_crc_q, rx_crc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d, sop_pend_q, sop_pend_d, err_seen_q, err_seen_d;
  logic        push_d, sop_d, eop_d, done_d, ok_d, cerr_d;
  logic [7:0]  data_d;
  logic        abort, start, emit, emit_eop;

  always_comb begin
    rd_mid = rd_q;
    rd_nx  = rd_q;
    derr   = 1'b0;
    unique case (ones6)
      3'd4:    begin derr = rd_q;  rd_mid = 1'b1; end
      3'd2:    begin derr = !rd_q; rd_mid = 1'b0; end
      default: derr = ((s6 == 6'b111000) && rd_q) || ((s6 == 6'b000111) && !rd_q);
    endcase
    unique case (ones4)
      3'd3:    begin derr = derr || rd_mid;  rd_nx = 1'b1; end
      3'd1:    begin derr = derr || !rd_mid; rd_nx = 1'b0; end
      default: begin
        rd_nx = rd_mid;
        derr  = derr || ((s4 == 4'b1100) && rd_mid) || ((s4 == 4'b0011) && !rd_mid);
      end
    endcase
  end

  assign sym_err = !k285 && (!d6[5] || bad4 || derr);

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    crc_d      = crc_q;
    rx_crc_d   = rx_crc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sop_pend_d = sop_pend_q;
    err_seen_d = err_seen_q;
    push_d     = 1'b0;
    data_d     = dataout;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    done_d     = 1'b0;
    ok_d       = 1'b0;
    cerr_d     = 1'b0;
    abort      = 1'b0;
    start      = 1'b0;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    if (pushin) begin
      // K28.5 resynchronises RD: the RD- form leaves RD+, and vice versa
      rd_d = k285 ? (datain == K285Neg) : rd_nx;
      unique case (state_q)
        StIdle: start = k285;
        StData: begin
          if (k285) begin
            done_d = 1'b1;
            start  = 1'b1;
          end else if (sym_err) begin
            abort = 1'b1;
          end else if (k237) begin
            emit       = hold_vld_q;
            emit_eop   = 1'b1;
            hold_vld_d = 1'b0;
            cnt_d      = 2'd0;
            state_d    = StCrc;
          end else if (is_k) begin
            abort = 1'b1;
          end else begin
            crc_d      = crc_upd(crc_q, sym_byte);
            emit       = hold_vld_q;
            hold_d     = sym_byte;
            hold_vld_d = 1'b1;
          end
        end
        StCrc: begin
          if (is_k || sym_err) begin
            abort = 1'b1;
          end else begin
            rx_crc_d[8*cnt_q +: 8] = sym_byte;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = StEnd;
          end
        end
        StEnd: begin
          if (k285) begin
            done_d  = 1'b1;
            ok_d    = (rx_crc_q == ~crc_q) && !err_seen_q;
            state_d = StIdle;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (emit) begin
      push_d     = 1'b1;
      data_d     = hold_q;
      sop_d      = sop_pend_q;
      eop_d      = emit_eop;
      sop_pend_d = 1'b0;
    end
    if (start) begin
      state_d    = StData;
      crc_d      = 32'hFFFFFFFF;
      hold_vld_d = 1'b0;
      sop_pend_d = 1'b1;
      err_seen_d = 1'b0;
    end
    if (abort) begin
      done_d     = 1'b1;
      ok_d       = 1'b0;
      cerr_d     = sym_err;
      err_seen_d = err_seen_q || sym_err;
      hold_vld_d = 1'b0;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_q       <= 1'b0;
      crc_q      <= 32'hFFFFFFFF;
      rx_crc_q   <= 32'd0;
      cnt_q      <= 2'd0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      sop_pend_q <= 1'b0;
      err_seen_q <= 1'b0;
      pushout    <= 1'b0;
      dataout    <= 8'd0;
      sopout     <= 1'b0;
      eopout     <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      crc_q      <= crc_d;
      rx_crc_q   <= rx_crc_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sop_pend_q <= sop_pend_d;
      err_seen_q <= err_seen_d;
      pushout    <= push_d;
      dataout    <= data_d;
      sopout     <= sop_d;
      eopout     <= eop_d;
      frame_done <= done_d;
      crc_ok     <= ok_d;
      code_err   <= cerr_d;
    end
  end

endmodule
